pm_dump_tx: RTL

- Readback counterpart of the UART program loader. The loader accepts a byte count N, then N bytes, and packs them big-endian into 32-bit program-memory words.
- This block does the reverse. On a start pulse it reads NWORDS words from a synchronous memory read port and streams them into the UART TX FIFO.
- Stream format is identical to the loader's input format, so the host can verify program memory after loading.
- Sits between program memory (read port) and the UART TX interface (wr_uart / w_data / tx_full).

---
 rtl/pm_dump_tx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pm_dump_tx.sv
// pm_dump_tx: streams N program-memory words to the UART TX FIFO as {4N, bytes...}, MSB first
// Optional: define PM_DUMP_CHECKSUM_EN to append an XOR checksum of the data bytes.
module pm_dump_tx #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              I_START,
    input  logic [ADDR_W-1:0] I_NWORDS,
    output logic              O_RD_EN,
    output logic [ADDR_W-1:0] O_RD_ADDR,
    input  logic [31:0]       I_RD_DATA,
    input  logic              I_TX_FULL,
    output logic              O_WR_UART,
    output logic [7:0]        O_DATA_UART,
    output logic              O_BUSY,
    output logic              O_DONE
);
    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        READ,
        WAIT_DATA,
        SEND_BYTE,
`ifdef PM_DUMP_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

`ifdef PM_DUMP_CHECKSUM_EN
    localparam state_t LAST = CSUM;
`else
    localparam state_t LAST = DONE;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] n_q, n_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [31:0]       shift_q, shift_d;
    logic [ADDR_W-1:0] idx_nx;
    logic [7:0]        header;
`ifdef PM_DUMP_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    assign idx_nx = idx_q + ADDR_W'(1);
    assign header = 8'({n_q, 2'b00});

    // state and datapath registers; reset aborts any dump in progress
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
`ifdef PM_DUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
`ifdef PM_DUMP_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // next state and outputs; every byte write is gated by !I_TX_FULL in the same cycle
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        idx_d       = idx_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
`ifdef PM_DUMP_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        O_RD_EN     = 1'b0;
        O_RD_ADDR   = '0;
        O_WR_UART   = 1'b0;
        O_DATA_UART = 8'h00;
        O_BUSY      = 1'b1;
        O_DONE      = 1'b0;
        case (state_q)
            IDLE: begin
                O_BUSY = 1'b0;
                if (I_START) begin
                    n_d     = I_NWORDS;
                    idx_d   = '0;
`ifdef PM_DUMP_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                    state_d = HEADER;
                end
            end
            HEADER: begin
                O_DATA_UART = header;
                O_WR_UART   = !I_TX_FULL;
                if (!I_TX_FULL) state_d = (n_q == '0) ? LAST : READ;
            end
            READ: begin
                O_RD_EN   = 1'b1;
                O_RD_ADDR = ADDR_W'(BASE_ADDR) + idx_q;
                state_d   = WAIT_DATA;
            end
            WAIT_DATA: begin
                shift_d = I_RD_DATA;
                bcnt_d  = 2'd0;
                state_d = SEND_BYTE;
            end
            SEND_BYTE: begin
                O_DATA_UART = shift_q[31:24];
                O_WR_UART   = !I_TX_FULL;
                if (!I_TX_FULL) begin
                    shift_d = {shift_q[23:0], 8'h00};
                    bcnt_d  = bcnt_q + 2'd1;
`ifdef PM_DUMP_CHECKSUM_EN
                    csum_d  = csum_q ^ shift_q[31:24];
`endif
                    if (bcnt_q == 2'd3) begin
                        idx_d   = idx_nx;
                        state_d = (idx_nx == n_q) ? LAST : READ;
                    end
                end
            end
`ifdef PM_DUMP_CHECKSUM_EN
            CSUM: begin
                O_DATA_UART = csum_q;
                O_WR_UART   = !I_TX_FULL;
                if (!I_TX_FULL) state_d = DONE;
            end
`endif
            DONE: begin
                O_BUSY  = 1'b0;
                O_DONE  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
